sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS, default 20: SRAM byte-address width.
REQ-002 SHALL have parameter DATA, default 8: SRAM data width (one byte).
REQ-003 SHALL have parameter MEM_BYTES, default 1024: populated SRAM bytes, used only under REQ-024.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  CPU request present.
REQ-007 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-008 SHALL have port req_write  input  1  1 = word write, 0 = word read.
REQ-009 SHALL have port req_addr  input  ADDRESS  byte address; must be word-aligned.
REQ-010 SHALL have port req_wdata  input  32  write word, little-endian.
REQ-011 SHALL have port req_be  input  4  write byte enables; ignored on reads.
REQ-012 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port rsp_rdata  output  32  read word; 0 for writes and errors.
REQ-014 SHALL have port rsp_err  output  1  request rejected; qualified by rsp_valid.
REQ-015 SHALL have ports sram_addr (output, ADDRESS), sram_wdata (output, DATA), sram_rdata (input, DATA), sram_read, sram_write and sram_cs (outputs, 1), connecting to the SRAM addr, data_in, data_out, read, write and chip_select pins.

Function
REQ-016 SHALL assert req_ready only in state IDLE; acceptance = req_valid & req_ready at edge E0.
REQ-017 SHALL implement the FSM IDLE -> ACCESS (4 cycles, byte index 0..3) -> DRAIN -> IDLE, or IDLE -> ERR -> IDLE.
REQ-018 SHALL drive all SRAM outputs from registers; byte i is presented with sram_addr=base+i in the cycle after edge E(i), and the SRAM samples it at E(i+1).
REQ-019 SHALL, on a read, assert sram_cs=1, sram_read=1 and sram_write=0 for every byte, and capture byte i from sram_rdata at E(i+2) into rsp_rdata[8i+7:8i].
REQ-020 SHALL, on a write, drive sram_wdata=req_wdata[8i+7:8i] with sram_write=1 and sram_read=0; sram_cs=1 only when req_be[i]=1, otherwise the slot is idle but still consumes its cycle.
REQ-021 SHALL assert rsp_valid during the cycle after E5 for both reads and writes, giving a fixed 5-cycle latency with no backpressure; req_ready rises in that same cycle.
REQ-022 SHALL treat req_addr[1:0]!=0 as misaligned: make no SRAM access, go to ERR, and pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 in the cycle after E1.
REQ-023 SHALL hold sram_cs, sram_read and sram_write low in IDLE, DRAIN and ERR; addresses do not wrap within a word because the base is aligned.

Configuration
REQ-024 SHALL, when SRAM_CTRL_BOUNDS_EN is defined, treat req_addr+3 >= MEM_BYTES as an error handled exactly like REQ-022; without the macro, no bounds check exists and the address passes unmodified.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, req_ready=0 while rst_n is low, sram_cs/read/write=0, sram_addr=0, sram_wdata=0, rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-026 SHALL discard any in-flight request on reset, issuing no response for it, and assert req_ready in the first cycle after rst_n deasserts.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, ACCESS, DRAIN, ERR) and the constant WORD_BYTES=4 in a shared package, sram_ctrl_pkg.
REQ-028 SHALL be a single module with no sub-module; the SRAM is instantiated alongside it by the parent.

Verification
REQ-029 SHALL cover: write 0xDEADBEEF to 0x10 with be=4'hF -> sram_cs high on 4 consecutive cycles with addr 0x10..0x13 and data EF, BE, AD, DE; rsp_valid 5 cycles after accept with rsp_err=0.
REQ-030 SHALL cover: read 0x10 after that write -> rsp_rdata=0xDEADBEEF, rsp_valid exactly 5 cycles after accept.
REQ-031 SHALL cover: write 0x11223344 to 0x20 with be=4'b0101, then read 0x20 -> only bytes 0x20 and 0x22 are written, and the read returns 0xXX22XX44 with unwritten bytes at their prior values.
REQ-032 SHALL cover: read 0x13 -> no sram_cs activity, and rsp_valid=1, rsp_err=1, rsp_rdata=0 one cycle after accept.
REQ-033 SHALL cover: rst_n pulled low at access byte 2 -> SRAM strobes drop immediately, no rsp_valid is issued, and req_ready=1 one cycle after release.
REQ-034 SHALL cover, with SRAM_CTRL_BOUNDS_EN and MEM_BYTES=1024: read 0x3FC -> ok; read 0x400 -> rsp_err=1 with no SRAM access.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the byte-wide SRAM controller: the controller FSM
// state encoding and the number of SRAM bytes that make up one CPU word.
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

   // IDLE   : waiting for a CPU request (the only state with req_ready high)
   // ACCESS : four byte slots, one SRAM byte presented per cycle
   // DRAIN  : last read byte returns from the SRAM; strobes already low
   // ERR    : rejected request, error response on the way out
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DRAIN  = 2'd2,
      ERR    = 2'd3
   } state_t;

   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
// Turns 32-bit CPU word requests into four sequential byte accesses on a
// synchronous byte-wide SRAM (address/control sampled on a rising edge, read
// data available after that same edge). Fixed latency: a request accepted at
// edge E0 responds in the cycle after E5; a rejected request responds in the
// cycle after E1. No backpressure on the response side.
//
// Parameters
//   ADDRESS   : SRAM byte-address width
//   DATA      : SRAM data width (one byte)
//   MEM_BYTES : populated SRAM bytes, only used by the optional bounds check
//
// Ports
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid / req_ready      : CPU request handshake
//   req_write, req_addr,
//   req_wdata, req_be          : request command, word address, data, byte enables
//   rsp_valid, rsp_rdata,
//   rsp_err                    : one-cycle response pulse, read word, reject flag
//   sram_addr, sram_wdata,
//   sram_rdata, sram_read,
//   sram_write, sram_cs        : SRAM pins; every output comes from a flop
//
// Build option
//   SRAM_CTRL_BOUNDS_EN : when defined, words extending to or past MEM_BYTES
//                         are rejected like misaligned requests.
// ---------------------------------------------------------------------------
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDRESS   = 20,
   parameter int DATA      = 8,
   parameter int MEM_BYTES = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [ADDRESS-1:0] req_addr,
   input  logic [31:0]        req_wdata,
   input  logic [3:0]         req_be,
   output logic               rsp_valid,
   output logic [31:0]        rsp_rdata,
   output logic               rsp_err,
   output logic [ADDRESS-1:0] sram_addr,
   output logic [DATA-1:0]    sram_wdata,
   input  logic [DATA-1:0]    sram_rdata,
   output logic               sram_read,
   output logic               sram_write,
   output logic               sram_cs
);

   state_t             state_q, state_d;
   logic [1:0]         idx_q, idx_d;

   // Request captured at acceptance, used for byte slots 1..3
   logic [ADDRESS-1:0] base_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;
   logic               write_q;

   logic [31:0]        rdata_q;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_err_q, rsp_err_d;

   logic [ADDRESS-1:0] sram_addr_q, sram_addr_d;
   logic [DATA-1:0]    sram_wdata_q, sram_wdata_d;
   logic               sram_cs_q, sram_cs_d;
   logic               sram_read_q, sram_read_d;
   logic               sram_write_q, sram_write_d;

   // Byte slot to present next cycle
   logic               accept;
   logic               issue;
   logic [1:0]         issue_idx;
   logic [ADDRESS-1:0] issue_base;
   logic [31:0]        issue_wdata;
   logic [3:0]         issue_be;
   logic               issue_write;

   logic               bad_req;

`ifdef SRAM_CTRL_BOUNDS_EN
   // One extra bit so base+3 cannot wrap around the address space.
   logic [ADDRESS:0]   last_addr;
   assign last_addr = {1'b0, req_addr} + (ADDRESS+1)'(WORD_BYTES - 1);
   assign bad_req   = (|req_addr[1:0]) || (last_addr >= (ADDRESS+1)'(MEM_BYTES));
`else
   assign bad_req   = |req_addr[1:0];
`endif

   // Gated with rst_n so the CPU sees not-ready for the whole reset pulse,
   // while the state register itself already sits in IDLE.
   assign req_ready = rst_n && (state_q == IDLE);

   // ---------------------------------------------------------------------
   // Next state and next values of the registered SRAM/response outputs
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      accept      = 1'b0;
      issue       = 1'b0;
      issue_idx   = 2'd0;
      issue_base  = base_q;
      issue_wdata = wdata_q;
      issue_be    = be_q;
      issue_write = write_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept = 1'b1;
               if (bad_req) begin
                  state_d = ERR;
               end else begin
                  // Slot 0 comes straight from the request port so it is on
                  // the pins in the cycle right after acceptance.
                  state_d     = ACCESS;
                  idx_d       = 2'd0;
                  issue       = 1'b1;
                  issue_idx   = 2'd0;
                  issue_base  = req_addr;
                  issue_wdata = req_wdata;
                  issue_be    = req_be;
                  issue_write = req_write;
               end
            end
         end
         ACCESS: begin
            if (idx_q == 2'(WORD_BYTES - 1)) begin
               state_d = DRAIN;
            end else begin
               idx_d     = idx_q + 2'd1;
               issue     = 1'b1;
               issue_idx = idx_q + 2'd1;
            end
         end
         DRAIN: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
         end
         ERR: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // A write slot with its enable clear keeps sram_write up but leaves the
      // chip deselected, so the slot still takes its cycle.
      sram_cs_d    = issue && (!issue_write || issue_be[issue_idx]);
      sram_read_d  = issue && !issue_write;
      sram_write_d = issue && issue_write;
      sram_addr_d  = issue ? issue_base + ADDRESS'(issue_idx) : sram_addr_q;
      sram_wdata_d = (issue && issue_write) ? issue_wdata[DATA*issue_idx +: DATA]
                                            : sram_wdata_q;
   end

   // ---------------------------------------------------------------------
   // State, request capture, read assembly and output registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= 2'd0;
         base_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         write_q      <= 1'b0;
         rdata_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         sram_cs_q    <= 1'b0;
         sram_read_q  <= 1'b0;
         sram_write_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         sram_cs_q    <= sram_cs_d;
         sram_read_q  <= sram_read_d;
         sram_write_q <= sram_write_d;

         if (accept) begin
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            write_q <= req_write;
            rdata_q <= '0;      // writes and errors return zero
         end

         // Byte i is sampled by the SRAM one edge after it is presented and
         // its data is captured here one edge later: byte idx-1 while in
         // ACCESS, the last byte while in DRAIN.
         if (!write_q) begin
            if (state_q == ACCESS && idx_q != 2'd0) begin
               rdata_q[DATA*(idx_q - 2'd1) +: DATA] <= sram_rdata;
            end else if (state_q == DRAIN) begin
               rdata_q[DATA*(WORD_BYTES - 1) +: DATA] <= sram_rdata;
            end
         end
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_rdata  = rdata_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;
   assign sram_cs    = sram_cs_q;
   assign sram_read  = sram_read_q;
   assign sram_write = sram_write_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
// Bench for sram_ctrl with a behavioural synchronous byte SRAM. Each request
// pushes its expected SRAM byte accesses (with the cycle they must appear in)
// and its expected response onto queues; a negedge monitor pops accesses as
// sram_cs is seen, and the response waiter pops responses.
// Honours SRAM_CTRL_BOUNDS_EN for the out-of-range expectations.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

   localparam int ADDRESS   = 20;
   localparam int DATA      = 8;
   localparam int MEM_BYTES = 1024;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } rsp_t;

   typedef struct {
      int                 cyc;
      logic [ADDRESS-1:0] addr;
      logic [DATA-1:0]    wdata;
      logic               wr;
   } acc_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic               req_write = 1'b0;
   logic [ADDRESS-1:0] req_addr = '0;
   logic [31:0]        req_wdata = '0;
   logic [3:0]         req_be = '0;
   logic               rsp_valid;
   logic [31:0]        rsp_rdata;
   logic               rsp_err;
   logic [ADDRESS-1:0] sram_addr;
   logic [DATA-1:0]    sram_wdata;
   logic [DATA-1:0]    sram_rdata = '0;
   logic               sram_read;
   logic               sram_write;
   logic               sram_cs;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   rsp_t rsp_q[$];
   acc_t acc_q[$];

   logic [7:0] sram_mem [2048];
   logic [7:0] shadow   [2048];

   sram_ctrl #(
      .ADDRESS   (ADDRESS),
      .DATA      (DATA),
      .MEM_BYTES (MEM_BYTES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_read  (sram_read),
      .sram_write (sram_write),
      .sram_cs    (sram_cs)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous SRAM: address/control sampled at the edge, data out after it
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_write) sram_mem[sram_addr[10:0]] <= sram_wdata;
         if (sram_read)  sram_rdata <= sram_mem[sram_addr[10:0]];
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      else
         n_pass++;
   endtask

   // Access monitor: every chip select must match the next expected access
   always @(negedge clk) begin
      if (rst_n && sram_cs) begin
         if (acc_q.size() == 0) begin
            check("spurious_cs", 32'(sram_cs), 32'd0);
         end else begin
            acc_t a;
            a = acc_q.pop_front();
            check("acc_cycle", 32'(cyc), 32'(a.cyc));
            check("acc_addr",  32'(sram_addr), 32'(a.addr));
            check("acc_write", 32'(sram_write), 32'(a.wr));
            check("acc_read",  32'(sram_read), 32'(!a.wr));
            if (a.wr) check("acc_wdata", 32'(sram_wdata), 32'(a.wdata));
         end
      end
   end

   function automatic logic is_bad(input logic [ADDRESS-1:0] addr);
      logic bad;
      bad = (addr[1:0] != 2'b00);
`ifdef SRAM_CTRL_BOUNDS_EN
      if (int'(addr) + 3 >= MEM_BYTES) bad = 1'b1;
`endif
      return bad;
   endfunction

   // Drive one request, push its expectations, return just after accept edge
   task automatic send(input logic wr, input logic [ADDRESS-1:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
      rsp_t r;
      acc_t a;
      int   e0;
      @(negedge clk);
      check("ready_idle", 32'(req_ready), 32'd1);
      e0      = cyc + 1;
      r.rdata = 32'd0;
      r.err   = is_bad(addr);
      r.lat   = r.err ? 1 : 5;
      if (!r.err) begin
         for (int i = 0; i < 4; i++) begin
            logic [10:0] ix;
            ix = 11'(addr + ADDRESS'(i));
            if (!wr || be[i]) begin
               a.cyc   = e0 + i;
               a.addr  = addr + ADDRESS'(i);
               a.wr    = wr;
               a.wdata = wr ? wd[8*i +: 8] : 8'h00;
               acc_q.push_back(a);
               if (wr) shadow[ix] = wd[8*i +: 8];
            end
            if (!wr) r.rdata[8*i +: 8] = shadow[ix];
         end
      end
      rsp_q.push_back(r);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      req_be    = be;
      @(posedge clk);
   endtask

   task automatic wait_rsp();
      rsp_t r;
      int   k;
      logic got;
      got = 1'b0;
      k   = 0;
      while (!got && k <= 20) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (rsp_valid) got = 1'b1;
         else k++;
      end
      r = rsp_q.pop_front();
      if (!got) begin
         check("rsp_timeout", 32'(rsp_valid), 32'd1);
      end else begin
         check("rsp_latency", 32'(k), 32'(r.lat));
         check("rsp_err",     32'(rsp_err), 32'(r.err));
         check("rsp_rdata",   rsp_rdata, r.rdata);
         check("rsp_ready",   32'(req_ready), 32'd1);
         @(negedge clk);
         check("rsp_pulse",   32'(rsp_valid), 32'd0);
      end
      check("acc_left", 32'(acc_q.size()), 32'd0);
      acc_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(req_ready),  32'd0);
      check({tag, "_cs"},    32'(sram_cs),    32'd0);
      check({tag, "_rd"},    32'(sram_read),  32'd0);
      check({tag, "_wr"},    32'(sram_write), 32'd0);
      check({tag, "_addr"},  32'(sram_addr),  32'd0);
      check({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
      check({tag, "_valid"}, 32'(rsp_valid),  32'd0);
      check({tag, "_err"},   32'(rsp_err),    32'd0);
      check({tag, "_rdata"}, rsp_rdata,       32'd0);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) begin
         sram_mem[i] = 8'(i * 7 + 3);
         shadow[i]   = 8'(i * 7 + 3);
      end

      // Power-on reset
      #3;
      check_reset_outputs("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("por_ready_after", 32'(req_ready), 32'd1);

      // Full-word write then read-back
      send(1'b1, 20'h00010, 32'hDEADBEEF, 4'hF);
      wait_rsp();
      send(1'b0, 20'h00010, 32'h0, 4'h0);
      wait_rsp();

      // Partial write, read-back keeps unwritten bytes
      send(1'b1, 20'h00020, 32'h11223344, 4'b0101);
      wait_rsp();
      send(1'b0, 20'h00020, 32'h0, 4'h0);
      wait_rsp();

      // Misaligned: no SRAM activity, error after one cycle
      send(1'b0, 20'h00013, 32'h0, 4'h0);
      wait_rsp();
      send(1'b1, 20'h00042, 32'hCAFEF00D, 4'hF);
      wait_rsp();

      // Mixed random aligned traffic
      for (int n = 0; n < 8; n++) begin
         logic [ADDRESS-1:0] a;
         a = ADDRESS'({$urandom_range(16, 40), 2'b00});
         send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
         wait_rsp();
      end

      // Top of populated memory and the first word past it
      send(1'b0, 20'h003FC, 32'h0, 4'h0);
      wait_rsp();
      send(1'b0, 20'h00400, 32'h0, 4'h0);
      wait_rsp();

      // Reset in the middle of a read, with byte 2 on the pins
      send(1'b0, 20'h00010, 32'h0, 4'h0);
      repeat (3) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid");
      acc_q.delete();
      rsp_q.delete();
      repeat (2) begin
         @(negedge clk);
         check("mid_no_rsp_lo", 32'(rsp_valid), 32'd0);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("mid_ready_after", 32'(req_ready), 32'd1);
      repeat (6) begin
         @(negedge clk);
         check("mid_no_rsp_hi", 32'(rsp_valid | sram_cs), 32'd0);
      end

      // Controller still healthy after the abort
      send(1'b0, 20'h00010, 32'h0, 4'h0);
      wait_rsp();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

endmodule
